// File: rtl/instr_queue.sv
// Instruction queue between fetch and decode: a DEPTH-entry FIFO of
// {pc, instr, exc} with flush. The head is presented combinationally and
// reads as all-zero (a NOP) when the queue is empty.
// Optional feature: define IQ_BYPASS_EN to let an instruction offered to an
// empty queue appear at the output in the same cycle.
module instr_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_pc,
  input  logic [31:0]                in_instr,
  input  logic                       in_exc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic                       out_exc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  // Entry storage; written only on a push, never reset.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic        exc_mem   [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic empty;
  logic bypass_take;
  logic push_en;
  logic pop_en;

  assign empty = (count_q == '0);
  assign count = count_q;

  // Handshake decode: in_ready depends only on state and flush, never out_ready.
  always_comb begin
    in_ready = (count_q < DEPTH_C) && !flush;
`ifdef IQ_BYPASS_EN
    bypass_take = empty && in_valid && !flush;
    out_valid   = !empty || bypass_take;
    // A bypassed instruction consumed in the same cycle is never stored.
    push_en     = in_valid && in_ready && !(bypass_take && out_ready);
`else
    bypass_take = 1'b0;
    out_valid   = !empty;
    push_en     = in_valid && in_ready;
`endif
    // Only stored entries move the read pointer; flush cancels any pop.
    pop_en = out_valid && out_ready && !empty && !flush;
  end

  // Head fields: stored head, the bypassed input, or zeros (NOP) when empty.
  always_comb begin
    out_pc    = 32'h0;
    out_instr = 32'h0;
    out_exc   = 1'b0;
    if (!empty) begin
      out_pc    = pc_mem[rd_ptr_q];
      out_instr = instr_mem[rd_ptr_q];
      out_exc   = exc_mem[rd_ptr_q];
    end else if (bypass_take) begin
      out_pc    = in_pc;
      out_instr = in_instr;
      out_exc   = in_exc;
    end
  end

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_en)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push_en && !pop_en)      count_d = count_q + ONE_C;
      else if (pop_en && !push_en) count_d = count_q - ONE_C;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write at the write pointer; push_en is already masked by flush.
  always_ff @(posedge clk) begin
    if (push_en) begin
      pc_mem[wr_ptr_q]    <= in_pc;
      instr_mem[wr_ptr_q] <= in_instr;
      exc_mem[wr_ptr_q]   <= in_exc;
    end
  end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8: number of entries; a power of two, at least 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1 bit: discard all entries (exception, ERET or branch redirect).
REQ-005 The block SHALL have port in_valid, input, 1 bit: fetch offers an instruction.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the queue accepts an instruction.
REQ-007 The block SHALL have port in_pc, input, 32 bits: PC of the offered instruction.
REQ-008 The block SHALL have port in_instr, input, 32 bits: instruction word.
REQ-009 The block SHALL have port in_exc, input, 1 bit: fetch-side exception flag (address error or TLB).
REQ-010 The block SHALL have port out_valid, output, 1 bit: head entry available to decode.
REQ-011 The block SHALL have port out_ready, input, 1 bit: decode consumes the head.
REQ-012 The block SHALL have ports out_pc (32 bits), out_instr (32 bits) and out_exc (1 bit), all outputs: head entry fields.
REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current number of occupied entries.

Function
REQ-014 A push SHALL occur when in_valid && in_ready, and a pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL be (count < DEPTH) && !flush, with no combinational dependence on out_ready.
REQ-016 out_valid SHALL be (count != 0) when IQ_BYPASS_EN is undefined.
REQ-017 Entries SHALL leave in strict FIFO order, with pc, instr and exc kept together per entry.
REQ-018 Read and write pointers SHALL be $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0.
REQ-019 On push only, count SHALL increase by 1; on pop only, it SHALL decrease by 1; on a simultaneous push and pop, it SHALL stay unchanged.
REQ-020 On a simultaneous push and pop, both pointers SHALL advance.
REQ-021 Full (count == DEPTH): in_ready SHALL be 0, a pop SHALL still be allowed, and in_ready SHALL return to 1 the cycle after the pop.
REQ-022 Empty: out_valid SHALL be 0, and out_instr SHALL be 32'h0 (NOP), out_pc 32'h0 and out_exc 0.
REQ-023 Without bypass, latency SHALL be 1 cycle from push to out_valid.
REQ-024 flush SHALL have the highest priority: next cycle count == 0 and both pointers == 0.
REQ-025 A push or pop presented in a flush cycle SHALL be ignored.
REQ-026 in_ready SHALL be 0 during the flush cycle and SHALL return to 1 the following cycle.
REQ-027 out_valid SHALL remain a function of the current state during a flush cycle; decode discards it under the same flush.
REQ-028 Entry storage SHALL be written only on a push and SHALL need no reset.

Reset
REQ-029 With rst_n == 0 at a rising edge, count, rd_ptr and wr_ptr SHALL become 0.
REQ-030 After reset, out_valid SHALL be 0, in_ready SHALL be 1 once rst_n is high, and out_pc, out_instr and out_exc SHALL be 0.
REQ-031 Reset mid-operation SHALL discard all entries exactly as flush does, with no entry surviving.

Configuration
REQ-032 Macro IQ_BYPASS_EN defined: when count == 0 and in_valid && !flush, out_valid SHALL be 1 in the same cycle, and out_pc, out_instr and out_exc SHALL equal the in_* fields.
REQ-033 Macro IQ_BYPASS_EN defined: if out_ready is also 1 in that cycle, the entry SHALL pass through without being written, and count and pointers SHALL stay unchanged.
REQ-034 Macro IQ_BYPASS_EN defined: if out_ready is 0 in that cycle, the entry SHALL be written normally.
REQ-035 Macro IQ_BYPASS_EN undefined: there SHALL be no bypass path, and REQ-016 and REQ-023 SHALL apply.

Verification
REQ-036 The bench SHALL cover: reset, then push pc=0xBFC00000 instr=0x3C081234 -> next cycle out_valid=1, out_pc=0xBFC00000, out_instr=0x3C081234, count=1.
REQ-037 The bench SHALL cover: push 8 entries with out_ready=0 -> count=8 and in_ready=0; a 9th offer is not accepted; one pop -> in_ready=1 the next cycle, count=7.
REQ-038 The bench SHALL cover: 20 back-to-back pushes and pops with pointers wrapping -> outputs appear in order, count stays constant, and no pc is lost or duplicated.
REQ-039 The bench SHALL cover: 5 entries held, flush=1 together with in_valid=1 -> next cycle count=0, out_valid=0, out_instr=0; the pushed entry never appears.
REQ-040 The bench SHALL cover: entry with in_exc=1 pc=0x00000003 -> out_exc=1 with out_pc=0x00000003 at the head.
REQ-041 The bench SHALL cover, with IQ_BYPASS_EN: empty queue, in_valid=1 and out_ready=1 -> out_valid=1 in the same cycle, out_instr=in_instr, count stays 0.
